uart_boot_loader: RTL and testbench



---
 rtl/uart_boot_loader.sv | 204 ++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// UART boot loader: parses an A5/LEN/data/CHK frame and writes the image into memory port 0.
// Loader writes are a one-cycle strobe the cycle after each word's 4th byte; after DONE, port 0 passes straight through from the core.
module uart_boot_loader #(
  parameter int ADDR_W         = 9,
  parameter int MAX_WORDS      = 512,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              boot_skip_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  input  logic              core_csb_i,
  input  logic              core_web_i,
  input  logic [3:0]        core_wmask_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [31:0]       core_din_i,
  output logic              mem_csb_o,
  output logic              mem_web_o,
  output logic [3:0]        mem_wmask_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_din_o,
  output logic              core_rst_no,
  output logic              boot_done_o,
  output logic              boot_err_o
);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_START, S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        chk_q, chk_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_dat_q, wr_dat_d;
  logic              rst_n_q, rst_n_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [15:0]       len16;
  logic [ADDR_W:0]   idx_nxt;
  logic [31:0]       word_nxt;
  logic              active;
  logic              timeout;

  assign len16    = {rx_data_i, len_lo_q};
  assign idx_nxt  = idx_q + (ADDR_W+1)'(1);
  assign word_nxt = {rx_data_i, word_q[31:8]};
  assign active   = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                    (state_q == S_DATA)   || (state_q == S_CHECK);
  assign timeout  = active && !rx_valid_i && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    len_lo_d  = len_lo_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    chk_d     = chk_q;
    tmo_d     = (rx_valid_i || !active) ? '0 : tmo_q + TMO_W'(1);
    wr_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_dat_d  = wr_dat_q;
    rst_n_d   = rst_n_q;
    done_d    = done_q;
    err_d     = err_q;

    case (state_q)
      S_START: begin
        if (boot_skip_i) begin
          state_d = S_DONE;
          rst_n_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          state_d = S_SYNC;
        end
      end
      S_SYNC, S_ERROR: begin
        if (rx_valid_i && rx_data_i == 8'hA5) begin
          state_d = S_LEN_LO;
          err_d   = 1'b0;
          chk_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_LEN_LO: begin
        if (rx_valid_i) begin
          len_lo_d = rx_data_i;
          chk_d    = chk_q ^ rx_data_i;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (rx_valid_i) begin
          chk_d = chk_q ^ rx_data_i;
          len_d = len16[ADDR_W:0];
          if (len16 > 16'(MAX_WORDS)) state_d = S_ERROR;
          else if (len16 == 16'd0)    state_d = S_CHECK;
          else                        state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_valid_i) begin
          chk_d  = chk_q ^ rx_data_i;
          word_d = word_nxt;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            wr_d      = 1'b1;
            wr_addr_d = idx_q[ADDR_W-1:0];
            wr_dat_d  = word_nxt;
            idx_d     = idx_nxt;
            // The write strobe lands in CHECK so a back-to-back CHK byte is not lost.
            if (idx_nxt == len_q) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (rx_valid_i) begin
          if (rx_data_i == chk_q) begin
            state_d = S_DONE;
            rst_n_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      default: ;
    endcase

    if (timeout) state_d = S_ERROR;

    if (state_d == S_ERROR && state_q != S_ERROR) begin
      err_d = 1'b1;
      idx_d = '0;
      chk_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= S_START;
      len_lo_q  <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      chk_q     <= '0;
      tmo_q     <= '0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_dat_q  <= '0;
      rst_n_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_lo_q  <= len_lo_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      chk_q     <= chk_d;
      tmo_q     <= tmo_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      wr_dat_q  <= wr_dat_d;
      rst_n_q   <= rst_n_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    if (state_q == S_DONE) begin
      mem_csb_o   = core_csb_i;
      mem_web_o   = core_web_i;
      mem_wmask_o = core_wmask_i;
      mem_addr_o  = core_addr_i;
      mem_din_o   = core_din_i;
    end else begin
      mem_csb_o   = ~wr_q;
      mem_web_o   = ~wr_q;
      mem_wmask_o = {4{wr_q}};
      mem_addr_o  = wr_addr_q;
      mem_din_o   = wr_dat_q;
    end
  end

  assign core_rst_no = rst_n_q;
  assign boot_done_o = done_q;
  assign boot_err_o  = err_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: expected memory writes queued by stimulus, popped by a strobe monitor.
module tb_uart_boot_loader;
  localparam int ADDR_W = 9;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              boot_skip_i;
  logic [7:0]        rx_data_i;
  logic              rx_valid_i;
  logic              core_csb_i;
  logic              core_web_i;
  logic [3:0]        core_wmask_i;
  logic [ADDR_W-1:0] core_addr_i;
  logic [31:0]       core_din_i;
  logic              mem_csb_o;
  logic              mem_web_o;
  logic [3:0]        mem_wmask_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_din_o;
  logic              core_rst_no;
  logic              boot_done_o;
  logic              boot_err_o;

  always #5 clk_i = ~clk_i;

  uart_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(512), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .boot_skip_i(boot_skip_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .core_csb_i(core_csb_i), .core_web_i(core_web_i), .core_wmask_i(core_wmask_i),
    .core_addr_i(core_addr_i), .core_din_i(core_din_i),
    .mem_csb_o(mem_csb_o), .mem_web_o(mem_web_o), .mem_wmask_o(mem_wmask_o),
    .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o),
    .core_rst_no(core_rst_no), .boot_done_o(boot_done_o), .boot_err_o(boot_err_o)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       dat;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] fr[$];
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every low-csb cycle must match the next queued write; a wider strobe pops an extra entry.
  always @(negedge clk_i) begin
    if (mem_csb_o == 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr_o, mem_din_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr_o), 32'(e.addr));
        check("wr_data", mem_din_o, e.dat);
        check("wr_web", 32'(mem_web_o), 32'd0);
        check("wr_wmask", 32'(mem_wmask_o), 32'hF);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    tick(1);
    rx_valid_i = 1'b0;
    if (gap > 0) tick(gap);
  endtask

  task automatic send_fr(input int gap);
    foreach (fr[i]) send(fr[i], gap);
  endtask

  function automatic logic [7:0] frame_xor();
    logic [7:0] x = 8'h00;
    for (int i = 1; i < fr.size(); i++) x = x ^ fr[i];
    return x;
  endfunction

  task automatic reset_and_check(input logic skip);
    reset_i     = 1'b0;
    boot_skip_i = skip;
    tick(1);
    check("rst_core_rst_no", 32'(core_rst_no), 32'd0);
    check("rst_boot_done", 32'(boot_done_o), 32'd0);
    check("rst_boot_err", 32'(boot_err_o), 32'd0);
    check("rst_mem_csb", 32'(mem_csb_o), 32'd1);
    check("rst_mem_web", 32'(mem_web_o), 32'd1);
    check("rst_mem_wmask", 32'(mem_wmask_o), 32'd0);
    check("rst_mem_addr", 32'(mem_addr_o), 32'd0);
    check("rst_mem_din", mem_din_o, 32'd0);
    reset_i = 1'b1;
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b0; boot_skip_i = 1'b0; rx_data_i = 8'h00; rx_valid_i = 1'b0;
    core_csb_i = 1'b1; core_web_i = 1'b1; core_wmask_i = 4'h0;
    core_addr_i = '0; core_din_i = 32'h0;
    tick(2);

    // Skip loading: DONE straight after START, core drives the port combinationally.
    reset_and_check(1'b1);
    check("skip_done", 32'(boot_done_o), 32'd1);
    check("skip_core_rst_no", 32'(core_rst_no), 32'd1);
    check("skip_err", 32'(boot_err_o), 32'd0);
    exp_q.push_back('{addr: 9'd5, dat: 32'hDEADBEEF});
    core_csb_i = 1'b0; core_web_i = 1'b0; core_wmask_i = 4'hF;
    core_addr_i = 9'd5; core_din_i = 32'hDEADBEEF;
    #1;
    check("pass_csb_same_cycle", 32'(mem_csb_o), 32'd0);
    check("pass_addr_same_cycle", 32'(mem_addr_o), 32'd5);
    tick(1);
    core_csb_i = 1'b1; core_web_i = 1'b1; core_wmask_i = 4'h0;
    tick(2);

    // Two-word frame.
    reset_and_check(1'b0);
    check("load_core_held", 32'(core_rst_no), 32'd0);
    fr = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    exp_q.push_back('{addr: 9'd0, dat: 32'h12345678});
    exp_q.push_back('{addr: 9'd1, dat: 32'hDEADBEEF});
    send_fr(1);
    send(frame_xor(), 1);
    check("load_done", 32'(boot_done_o), 32'd1);
    check("load_core_rst_no", 32'(core_rst_no), 32'd1);
    check("load_err", 32'(boot_err_o), 32'd0);

    // Bad checksum, then a clean resend from ERROR.
    reset_and_check(1'b0);
    exp_q.push_back('{addr: 9'd0, dat: 32'h12345678});
    exp_q.push_back('{addr: 9'd1, dat: 32'hDEADBEEF});
    send_fr(1);
    send(8'h03, 1);
    check("badchk_err", 32'(boot_err_o), 32'd1);
    check("badchk_core_held", 32'(core_rst_no), 32'd0);
    check("badchk_not_done", 32'(boot_done_o), 32'd0);
    exp_q.push_back('{addr: 9'd0, dat: 32'h12345678});
    exp_q.push_back('{addr: 9'd1, dat: 32'hDEADBEEF});
    send(8'hA5, 0);
    check("resend_err_cleared", 32'(boot_err_o), 32'd0);
    for (int i = 1; i < fr.size(); i++) send(fr[i], 1);
    send(frame_xor(), 1);
    check("resend_done", 32'(boot_done_o), 32'd1);
    check("resend_core_rst_no", 32'(core_rst_no), 32'd1);

    // Oversize length, then zero length out of ERROR.
    reset_and_check(1'b0);
    fr = {8'hA5, 8'h01, 8'h02};
    send_fr(0);
    check("len513_err", 32'(boot_err_o), 32'd1);
    tick(3);
    fr = {8'hA5, 8'h00, 8'h00};
    send_fr(1);
    send(8'h00, 1);
    check("len0_done", 32'(boot_done_o), 32'd1);
    check("len0_err", 32'(boot_err_o), 32'd0);

    // Noise in SYNC, then a stalled frame times out on the 16th idle cycle.
    reset_and_check(1'b0);
    fr = {8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    exp_q.push_back('{addr: 9'd0, dat: 32'h44332211});
    send_fr(1);
    tick(13);
    check("tmo_not_yet", 32'(boot_err_o), 32'd0);
    tick(3);
    check("tmo_err", 32'(boot_err_o), 32'd1);
    check("tmo_core_held", 32'(core_rst_no), 32'd0);

    // Back-to-back one-word frame.
    reset_and_check(1'b0);
    fr = {8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    exp_q.push_back('{addr: 9'd0, dat: 32'h11223344});
    send_fr(0);
    send(frame_xor(), 1);
    check("b2b_done", 32'(boot_done_o), 32'd1);

    // Reset in the middle of DATA, then a full reload.
    reset_and_check(1'b0);
    fr = {8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
    send_fr(1);
    reset_and_check(1'b0);
    fr = {8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    exp_q.push_back('{addr: 9'd0, dat: 32'h11223344});
    send_fr(1);
    send(frame_xor(), 1);
    check("reload_done", 32'(boot_done_o), 32'd1);
    check("reload_core_rst_no", 32'(core_rst_no), 32'd1);

    tick(4);
    check("writes_all_seen", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
